// File: rtl/i2c_master_sched.sv
// i2c_master_sched: round-robin single-master I2C controller, one single-byte transaction per grant
// Ports: clk, rst_n (async, active-low); per-requester req/addr/rw/wdata in;
//        grant (one-hot owner), busy, done (1-cycle pulse), ack_err (valid with done), rdata out;
//        scl push-pull out; sda open-drain (drives 0 or z, external pull-up).
module i2c_master_sched #(
    parameter int N_REQ   = 2,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] addr,
    input  logic [N_REQ-1:0]   rw,
    input  logic [8*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   grant,
    output logic               done,
    output logic               ack_err,
    output logic [7:0]         rdata,
    output logic               busy,
    output logic               scl,
    inout  wire                sda
);
    localparam int LW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int QW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE} state_t;
    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, win_oh;
    logic [LW-1:0]    last_q, last_d, win_idx;
    logic [6:0]       addr_q, addr_d;
    logic             rw_q, rw_d, err_q, err_d;
    logic [7:0]       wdata_q, wdata_d, shreg_q, shreg_d, rdata_q, rdata_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;
    logic [1:0]       quarter_q, quarter_d;
    logic [2:0]       bit_q, bit_d;
    logic             qend, slot_end, samp, sda_oe, sda_in;
    logic [7:0]       frame;
    assign sda_in = sda;
    assign sda    = sda_oe ? 1'b0 : 1'bz;
    // Round-robin: the smallest offset k after last_q with a pending request wins.
    always_comb begin
        win_oh  = '0;
        win_idx = last_q;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % N_REQ]) win_idx = LW'((int'(last_q) + k) % N_REQ);
        end
        win_oh[win_idx] = |req;
    end
    always_comb begin
        qend      = qcnt_q == QW'(CLK_DIV - 1);
        slot_end  = qend && quarter_q == 2'd3;
        samp      = qend && quarter_q == 2'd2;
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        qcnt_d    = qend ? '0 : qcnt_q + 1'b1;
        quarter_d = quarter_q + 2'(qend);
        case (state_q)
            IDLE: begin
                qcnt_d    = '0;
                quarter_d = '0;
                if (|req) begin
                    state_d = START;
                    grant_d = win_oh;
                    last_d  = win_idx;
                    addr_d  = addr[7*win_idx +: 7];
                    rw_d    = rw[win_idx];
                    wdata_d = wdata[8*win_idx +: 8];
                    err_d   = 1'b0;
                end
            end
            START: state_d = slot_end ? ADDR : START;
            ADDR: begin
                // bit_q wraps 0 -> 7 on its own, ready for the data byte.
                bit_d   = slot_end ? bit_q - 3'd1 : bit_q;
                state_d = (slot_end && bit_q == 3'd0) ? AACK : ADDR;
            end
            AACK: begin
                err_d   = (samp && sda_in) ? 1'b1 : err_q;
                state_d = slot_end ? (err_q ? STOP : DATA) : AACK;
            end
            DATA: begin
                shreg_d = samp ? {shreg_q[6:0], sda_in} : shreg_q;
                bit_d   = slot_end ? bit_q - 3'd1 : bit_q;
                state_d = (slot_end && bit_q == 3'd0) ? DACK : DATA;
            end
            DACK: begin
                err_d   = (samp && !rw_q && sda_in) ? 1'b1 : err_q;
                state_d = slot_end ? STOP : DACK;
            end
            STOP: state_d = slot_end ? DONE : STOP;
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                rdata_d = (rw_q && !err_q) ? shreg_q : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        frame   = {addr_q, rw_q};
        scl     = (state_q == IDLE || state_q == DONE) ? 1'b1 : quarter_q[1];
        // START pulls SDA low in Q3 and STOP releases it in Q3, both while SCL is high.
        sda_oe  = (state_q == START && quarter_q == 2'd3) ||
                  (state_q == ADDR && !frame[bit_q]) ||
                  (state_q == DATA && !rw_q && !wdata_q[bit_q]) ||
                  (state_q == STOP && quarter_q != 2'd3);
        done    = state_q == DONE;
        ack_err = done && err_q;
        rdata   = (done && rw_q && !err_q) ? shreg_q : rdata_q;
        // The winner is granted in the arbitration cycle itself so START can follow immediately.
        grant   = grant_q | ((state_q == IDLE && rst_n) ? win_oh : '0);
        busy    = |grant;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= LW'(N_REQ - 1);
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            shreg_q   <= '0;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= 3'd7;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            shreg_q   <= shreg_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_sched.sv
// tb_i2c_master_sched: scoreboard bench with an I2C slave model on the bus
module tb_i2c_master_sched;
    localparam int N = 2;
    localparam int D = 4;
    localparam int FULL_LAT = 1 + 80*D;
    localparam int NACK_LAT = 1 + 44*D;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] rw = '0;
    logic [7*N-1:0] addr = '0;
    logic [8*N-1:0] wdata = '0;
    logic [N-1:0] grant;
    logic done, ack_err, busy, scl;
    logic [7:0] rdata;
    wire sda;
    logic slv_low = 1'b0;
    assign sda = slv_low ? 1'b0 : 1'bz;
    pullup (sda);
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_master_sched #(.N_REQ(N), .CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .rw(rw), .wdata(wdata),
        .grant(grant), .done(done), .ack_err(ack_err), .rdata(rdata), .busy(busy),
        .scl(scl), .sda(sda)
    );

    typedef struct {
        int owner;
        logic [7:0] abyte;
        logic [7:0] dbyte;
        logic err;
        logic [7:0] rdata;
        int lat;
        int rises;
        logic dack;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    logic [7:0] exp_rdata = 8'h00;

    // Slave model: responds at 7'h2A, returns slave_byte on reads.
    logic [6:0] slave_addr = 7'h2A;
    logic [7:0] slave_byte = 8'h3C;
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] abyte = '0, dbyte = '0;
    logic dack_bit = 1'b0, matched = 1'b0;
    int bitn = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            slv_low = 1'b0;
            bitn = 0;
            matched = 1'b0;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            bitn = 0;
            matched = 1'b0;
        end else if (!prev_scl && scl) begin
            if (bitn < 8) abyte = {abyte[6:0], sda};
            else if (bitn >= 9 && bitn <= 16) dbyte = {dbyte[6:0], sda};
            else if (bitn == 17) dack_bit = sda;
            bitn++;
        end else if (prev_scl && !scl) begin
            if (bitn == 8) begin
                matched = abyte[7:1] == slave_addr;
                slv_low = matched;
            end else if (bitn >= 9 && bitn <= 16) slv_low = matched && abyte[0] && !slave_byte[16-bitn];
            else slv_low = matched && bitn == 17 && !abyte[0];
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // Monitor: grant changes and done pulses checked against the scoreboard.
    logic [N-1:0] prev_grant = '0;
    int g_cyc = 0;
    always @(negedge clk) begin
        if (grant !== prev_grant && grant !== '0) begin
            g_cyc = cyc;
            checks++;
            if (!$onehot(grant)) begin errors++; $display("FAIL grant_onehot got %b required one-hot", grant); end
        end
        prev_grant = grant;
        if (rst_n && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d, no transaction expected", cyc);
            end else begin
                cur = sb.pop_front();
                checks += 6;
                if (grant !== N'(1 << cur.owner)) begin errors++; $display("FAIL owner got %b required %b", grant, N'(1 << cur.owner)); end
                if (ack_err !== cur.err) begin errors++; $display("FAIL ack_err got %b required %b", ack_err, cur.err); end
                if (rdata !== cur.rdata) begin errors++; $display("FAIL rdata got %h required %h", rdata, cur.rdata); end
                if (cyc - g_cyc !== cur.lat) begin errors++; $display("FAIL done_latency got %0d required %0d", cyc - g_cyc, cur.lat); end
                if (bitn !== cur.rises) begin errors++; $display("FAIL scl_rises got %0d required %0d", bitn, cur.rises); end
                if (abyte !== cur.abyte) begin errors++; $display("FAIL bus_addr_byte got %h required %h", abyte, cur.abyte); end
                if (cur.rises == 19) begin
                    checks += 2;
                    if (dbyte !== cur.dbyte) begin errors++; $display("FAIL bus_data_byte got %h required %h", dbyte, cur.dbyte); end
                    if (dack_bit !== cur.dack) begin errors++; $display("FAIL dack_sda got %b required %b", dack_bit, cur.dack); end
                end
            end
        end
    end

    task automatic push_exp(input int owner, input logic [6:0] a, input logic r, input logic [7:0] w);
        exp_t e;
        logic present = a == slave_addr;
        if (r && present) exp_rdata = slave_byte;
        e.owner = owner;
        e.abyte = {a, r};
        e.dbyte = r ? slave_byte : w;
        e.err = !present;
        e.rdata = exp_rdata;
        e.lat = present ? FULL_LAT : NACK_LAT;
        e.rises = present ? 19 : 10;
        e.dack = r;
        sb.push_back(e);
    endtask

    task automatic issue(input int idx, input logic [6:0] a, input logic r, input logic [7:0] w);
        @(posedge clk);
        #1;
        addr[7*idx +: 7] = a;
        rw[idx] = r;
        wdata[8*idx +: 8] = w;
        req[idx] = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(input int idx, input string name);
        int n = 0;
        while (grant[idx] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (grant[idx] !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_grant got grant=%b busy=%b required grant[%0d]=1 busy=1", name, grant, busy, idx);
        end
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s_done_timeout waited %0d cycles, required done", name, n); end
    endtask

    task automatic check_idle(input string name);
        checks += 7;
        if (scl !== 1'b1) begin errors++; $display("FAIL %s_scl got %b required 1", name, scl); end
        if (sda !== 1'b1) begin errors++; $display("FAIL %s_sda got %b required released", name, sda); end
        if (grant !== '0) begin errors++; $display("FAIL %s_grant got %b required 0", name, grant); end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b required 0", name, busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL %s_done got %b required 0", name, done); end
        if (ack_err !== 1'b0) begin errors++; $display("FAIL %s_ack_err got %b required 0", name, ack_err); end
        if (rdata !== exp_rdata) begin errors++; $display("FAIL %s_rdata got %h required %h", name, rdata, exp_rdata); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write;
        push_exp(0, 7'h2A, 1'b0, 8'hA5);
        issue(0, 7'h2A, 1'b0, 8'hA5);
        wait_grant(0, "write");
        @(posedge clk);
        #1 req[0] = 1'b0;
        wait_done(400, "write");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_read;
        push_exp(1, 7'h2A, 1'b1, 8'h00);
        issue(1, 7'h2A, 1'b1, 8'h00);
        wait_grant(1, "read");
        @(posedge clk);
        #1 req[1] = 1'b0;
        wait_done(400, "read");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_addr_nack;
        push_exp(1, 7'h11, 1'b0, 8'h5A);
        issue(1, 7'h11, 1'b0, 8'h5A);
        wait_grant(1, "nack");
        @(posedge clk);
        #1 req[1] = 1'b0;
        wait_done(400, "nack");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_arbitration;
        int dones = 0;
        int n = 0;
        push_exp(0, 7'h2A, 1'b0, 8'h5A);
        push_exp(1, 7'h2A, 1'b0, 8'hC3);
        push_exp(0, 7'h2A, 1'b0, 8'h5A);
        push_exp(1, 7'h2A, 1'b0, 8'hC3);
        @(posedge clk);
        #1;
        addr = {7'h2A, 7'h2A};
        rw = '0;
        wdata = {8'hC3, 8'h5A};
        req = 2'b11;
        while (dones < 4 && n < 1600) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) dones++;
        end
        req = '0;
        checks++;
        if (dones != 4) begin errors++; $display("FAIL arb_done_count got %0d required 4", dones); end
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL arb_release got grant=%b busy=%b required 0", grant, busy); end
    endtask

    task automatic test_reset_mid;
        issue(0, 7'h2A, 1'b0, 8'h96);
        wait_grant(0, "abort");
        @(posedge clk);
        #1 req[0] = 1'b0;
        repeat (84) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_rdata = 8'h00;
        #1 check_idle("reset_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_exp(0, 7'h2A, 1'b0, 8'h3E);
        issue(0, 7'h2A, 1'b0, 8'h3E);
        wait_grant(0, "after_reset");
        @(posedge clk);
        #1 req[0] = 1'b0;
        wait_done(400, "after_reset");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_operand_stability;
        push_exp(1, 7'h2A, 1'b0, 8'h81);
        issue(1, 7'h2A, 1'b0, 8'h81);
        wait_grant(1, "stable");
        @(posedge clk);
        #1;
        wdata[15:8] = 8'h7E;
        addr[13:7] = 7'h11;
        rw[1] = 1'b1;
        req[1] = 1'b0;
        wait_done(400, "stable");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_addr_nack();
        test_arbitration();
        test_reset_mid();
        test_operand_stability();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d required 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_master_sched.md
# i2c_master_sched

Single-master I2C controller that time-shares one I2C bus between `N_REQ` local requesters. It arbitrates round-robin, captures the winner's command, and runs one complete single-byte transaction: START, 7-bit address + R/W, ACK check, one data byte, ACK/NACK, STOP. It sits between on-chip clients and the bus on which the slave devices hang. It reports completion, address/data NACK, and read data.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 1..8.
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-bit, legal range ≥2. One bit slot is 4*`CLK_DIV` cycles.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `N_REQ`: per-requester transaction request, level.
- `addr` in 7*`N_REQ`: slave address; requester i uses bits [7i+6:7i].
- `rw` in `N_REQ`: 1 = read, 0 = write.
- `wdata` in 8*`N_REQ`: write byte; requester i uses bits [8i+7:8i].
- `grant` out `N_REQ`: one-hot; high for the owner for the whole transaction.
- `done` out 1: one-cycle pulse at the end of each transaction.
- `ack_err` out 1: valid with `done`; 1 = address or data byte NACKed.
- `rdata` out 8: read byte; updated only at `done` of a successful read.
- `busy` out 1: high from grant until `done` inclusive.
- `scl` out 1: push-pull SCL (single master).
- `sda` inout 1: open-drain; the block drives only 0 or z, with an external pull-up.

## Operation
- States: IDLE, START, ADDR (8 slots, A6..A0 then R/W), AACK, DATA (8 slots, MSB first), DACK, STOP, DONE.
- IDLE: if any `req` is set, grant the first set index after `last` (wrap-around) and capture `addr`, `rw` and `wdata` into internal registers in the same cycle. `last` resets to `N_REQ`-1, so index 0 wins first after reset.
- Capture:
  - `req` and operand changes after grant are ignored.
  - `req` low mid-transaction does not abort.
  - If the owner's `req` is still high after `done`, the owner re-enters arbitration behind the other requesters.
- START slot: SDA high→low while SCL is high, then SCL low.
- ADDR: SDA driven with the bit value (0 = drive low, 1 = z).
- AACK:
  - SDA is released and sampled.
  - Sampled 1 (NACK): set `ack_err` and go to STOP.
  - Sampled 0: go to DATA.
- DATA, write: drive `wdata` bits. DACK then samples SDA; 1 sets `ack_err`.
- DATA, read: release SDA and shift in 8 sampled bits. DACK: master leaves SDA released (NACK, ends the read).
- STOP slot: SDA low while SCL rises, then SDA low→high while SCL is high.
- DONE:
  - One cycle with `done`=1.
  - `rdata` is loaded if `rw` and no error.
  - `grant` and `busy` clear on the next cycle, then return to IDLE.
- Reset (any time, including mid-transaction): immediately `scl`=1, `sda`=z, state IDLE.
- Reset values: `grant`=0, `done`=0, `ack_err`=0, `rdata`=8'h00, `busy`=0.

## Timing
- Bit slot of 4 quarters, each `CLK_DIV` cycles:
  - Q0, Q1: `scl`=0. SDA changes only at the start of Q0.
  - Q2, Q3: `scl`=1. SDA is sampled on the last cycle of Q2.
- START and STOP are the only slots that change SDA while `scl`=1, at the Q2/Q3 boundary.
- Grant in cycle g. The START slot begins in cycle g+1.
- Full transaction is 20 slots (START, 8, AACK, 8, DACK, STOP): `done` in cycle g+1+80*`CLK_DIV`.
- Address NACK is 11 slots: `done` in cycle g+1+44*`CLK_DIV`.
- Earliest next grant is the cycle after `done` returns to IDLE. Bus idle with `scl`=1 and `sda`=z is at least 1 cycle between transactions.
- Simultaneous requests in the same cycle are resolved purely by the round-robin order. No request is starved: the worst-case wait is (`N_REQ`-1) transactions.
- Quarter counter width is clog2(`CLK_DIV`). Bit counter width is 3 bits, counting 7 down to 0.

## Test plan
- Single write: `CLK_DIV`=4, req0 with addr 7'h2A, rw=0, wdata 8'hA5, slave model ACKs.
  - SDA shows 0x54, then A5, MSB-first.
  - `done` at g+321 with `ack_err`=0.
- Single read: req1 with addr 7'h2A, rw=1, slave returns 8'h3C.
  - `rdata`=8'h3C at `done`, `ack_err`=0.
  - SDA is released in the DACK slot.
- Address NACK: addr 7'h11 with no slave present.
  - `ack_err`=1, no DATA slots.
  - `done` at g+177 and `rdata` unchanged.
- Arbitration: req=2'b11 held continuously.
  - Grants alternate 01, 10, 01, 10.
  - Each `done` is followed by a one-hot `grant` change, with no overlap.
- Reset mid-ADDR: assert `rst_n`=0 during bit 3.
  - `scl`=1, `sda`=z and all outputs at reset values within the same cycle.
  - After release, a new req0 completes a normal transaction.
- Operand stability: change `wdata` and drop `req` after grant. The originally captured byte is still transmitted and `done` still pulses.
